instruction_fetch: RTL and testbench

- Requester side of the asynchronous-read instruction memory.
- Owns the program counter and drives the word address IMA; the memory returns IMRD combinationally in the same cycle.
- Registers the fetched word into an IF/ID stage register with a valid flag.
- Handles stall, branch redirect with wrong-path squash, and halt on a sentinel instruction.

---
 rtl/instruction_fetch.sv | 110 +++++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the word PC, reads an async-read memory and registers IF/ID with stall, redirect and halt.
// Optional delivered-instruction counter enabled by defining INSTRUCTION_FETCH_CNT_EN.
module instruction_fetch #(
  parameter int              DW        = 32,
  parameter int              AWL       = 5,
  parameter logic [AWL-1:0]  RESET_PC  = '0,
  parameter logic [DW-1:0]   HALT_WORD = {DW{1'b1}},
  parameter logic [DW-1:0]   NOP_WORD  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [AWL-1:0] IMA,
  input  logic [DW-1:0]  IMRD,
  input  logic           STALL,
  input  logic           BR_EN,
  input  logic [AWL-1:0] BR_TGT,
  output logic [DW-1:0]  INSTR,
  output logic [AWL-1:0] PC_OUT,
  output logic           VALID,
  output logic           HALTED,
  output logic [31:0]    FETCH_CNT
);

  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  state_t         state, state_nxt;
  logic [AWL-1:0] pc, pc_nxt;
  logic [DW-1:0]  instr, instr_nxt;
  logic [AWL-1:0] pc_out, pc_out_nxt;
  logic           valid, valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr;
    pc_out_nxt = pc_out;
    valid_nxt  = valid;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (BR_EN) begin
          // redirect squashes whatever sits in IF/ID, even if stalled
          pc_nxt    = BR_TGT;
          instr_nxt = NOP_WORD;
          valid_nxt = 1'b0;
        end else if (!STALL) begin
          instr_nxt  = IMRD;
          pc_out_nxt = pc;
          valid_nxt  = 1'b1;
          if (IMRD == HALT_WORD) state_nxt = HALT;
          else                   pc_nxt    = pc + AWL'(1);
        end
      end
      HALT: begin
        if (BR_EN) begin
          pc_nxt    = BR_TGT;
          instr_nxt = NOP_WORD;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!STALL) begin
          // halt word is consumed once downstream accepts it
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      instr  <= NOP_WORD;
      pc_out <= '0;
      valid  <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      instr  <= instr_nxt;
      pc_out <= pc_out_nxt;
      valid  <= valid_nxt;
    end
  end

  assign IMA    = pc;
  assign INSTR  = instr;
  assign PC_OUT = pc_out;
  assign VALID  = valid;
  assign HALTED = (state == HALT);

`ifdef INSTRUCTION_FETCH_CNT_EN
  logic        cap;
  logic [31:0] cnt;

  assign cap = (state == FETCH) && !BR_EN && !STALL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (cap && (cnt != '1))    cnt <= cnt + 32'd1;
  end

  assign FETCH_CNT = cnt;
`else
  assign FETCH_CNT = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch with a rule-level reference model.
module tb_instruction_fetch;
  localparam int DW = 32;
  localparam int AWL = 5;
  localparam logic [DW-1:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] NOPW  = 32'h0;

  logic           clk = 0;
  logic           rst_n = 0;
  logic [AWL-1:0] IMA;
  logic [DW-1:0]  IMRD;
  logic           STALL = 0, BR_EN = 0;
  logic [AWL-1:0] BR_TGT = '0;
  logic [DW-1:0]  INSTR;
  logic [AWL-1:0] PC_OUT;
  logic           VALID, HALTED;
  logic [31:0]    FETCH_CNT;

  logic [DW-1:0] mem [32];
  assign IMRD = mem[IMA];

  int checks = 0, failures = 0;

  // reference model: mode 0=boot 1=fetch 2=halt
  int          m_mode;
  int          m_pc, m_pcout;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  instruction_fetch #(.DW(DW), .AWL(AWL)) dut (
    .clk(clk), .rst_n(rst_n), .IMA(IMA), .IMRD(IMRD), .STALL(STALL),
    .BR_EN(BR_EN), .BR_TGT(BR_TGT), .INSTR(INSTR), .PC_OUT(PC_OUT),
    .VALID(VALID), .HALTED(HALTED), .FETCH_CNT(FETCH_CNT));

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt();
`ifdef INSTRUCTION_FETCH_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_pcout = 0; m_instr = NOPW; m_valid = 0; m_cnt = 0;
  endtask

  // advance model by the rules using inputs present before the edge, then clock
  task automatic step();
    logic [31:0] w;
    w = mem[m_pc];
    case (m_mode)
      0: m_mode = 1;
      1: if (BR_EN) begin
           m_pc = int'(BR_TGT); m_instr = NOPW; m_valid = 0;
         end else if (!STALL) begin
           m_instr = w; m_pcout = m_pc; m_valid = 1;
           if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
           if (w == HALTW) m_mode = 2;
           else m_pc = (m_pc + 1) % 32;
         end
      default: if (BR_EN) begin
           m_pc = int'(BR_TGT); m_instr = NOPW; m_valid = 0; m_mode = 1;
         end else if (!STALL) m_valid = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALTW) mem[i] = 32'h1234;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; STALL = 0; BR_EN = 0;
    #1;
    checks++; if (IMA !== 5'd0) begin failures++; $display("FAIL reset_ima got=%0d exp=0", IMA); end
    checks++; if (INSTR !== NOPW) begin failures++; $display("FAIL reset_instr got=%h exp=%h", INSTR, NOPW); end
    checks++; if (VALID !== 1'b0 || HALTED !== 1'b0) begin failures++; $display("FAIL reset_flags valid=%b halted=%b exp=0/0", VALID, HALTED); end
    checks++; if (FETCH_CNT !== 32'd0 || PC_OUT !== 5'd0) begin failures++; $display("FAIL reset_cnt_pcout cnt=%0d pcout=%0d exp=0/0", FETCH_CNT, PC_OUT); end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_run();
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    step();
    checks++; if (VALID !== 1'b0 || IMA !== 5'd0) begin failures++; $display("FAIL boot valid=%b ima=%0d exp=0/0", VALID, IMA); end
    step();
    checks++; if (INSTR !== 32'h11 || PC_OUT !== 5'd0 || VALID !== 1'b1) begin failures++; $display("FAIL run0 instr=%h pcout=%0d v=%b exp=11/0/1", INSTR, PC_OUT, VALID); end
    step();
    checks++; if (INSTR !== 32'h22 || PC_OUT !== 5'd1 || VALID !== 1'b1) begin failures++; $display("FAIL run1 instr=%h pcout=%0d v=%b exp=22/1/1", INSTR, PC_OUT, VALID); end
  endtask

  task automatic test_stall();
    STALL = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (INSTR !== 32'h22 || PC_OUT !== 5'd1 || IMA !== 5'd2 || VALID !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d instr=%h pcout=%0d ima=%0d exp=22/1/2", i, INSTR, PC_OUT, IMA); end
    end
    STALL = 0;
    step();
    checks++; if (INSTR !== 32'h33 || PC_OUT !== 5'd2) begin failures++; $display("FAIL stall_release instr=%h pcout=%0d exp=33/2", INSTR, PC_OUT); end
    checks++; if (FETCH_CNT !== exp_cnt()) begin failures++; $display("FAIL cnt_after3 got=%0d exp=%0d", FETCH_CNT, exp_cnt()); end
  endtask

  task automatic test_branch_over_stall();
    STALL = 1; BR_EN = 1; BR_TGT = 5'd5;
    step();
    STALL = 0; BR_EN = 0;
    checks++; if (VALID !== 1'b0 || INSTR !== NOPW || IMA !== 5'd5) begin failures++; $display("FAIL br_stall v=%b instr=%h ima=%0d exp=0/0/5", VALID, INSTR, IMA); end
    step();
    checks++; if (INSTR !== mem[5] || PC_OUT !== 5'd5 || VALID !== 1'b1) begin failures++; $display("FAIL br_target instr=%h pcout=%0d exp=%h/5", INSTR, PC_OUT, mem[5]); end
    checks++; if (FETCH_CNT !== exp_cnt()) begin failures++; $display("FAIL cnt_branch got=%0d exp=%0d", FETCH_CNT, exp_cnt()); end
  endtask

  task automatic test_wrap();
    mem[31] = 32'hAB; mem[0] = 32'h11;
    BR_EN = 1; BR_TGT = 5'd31;
    step();
    BR_EN = 0;
    step();
    checks++; if (INSTR !== 32'hAB || PC_OUT !== 5'd31) begin failures++; $display("FAIL wrap31 instr=%h pcout=%0d exp=ab/31", INSTR, PC_OUT); end
    step();
    checks++; if (INSTR !== 32'h11 || PC_OUT !== 5'd0) begin failures++; $display("FAIL wrap0 instr=%h pcout=%0d exp=11/0", INSTR, PC_OUT); end
  endtask

  task automatic test_halt();
    logic [31:0] c;
    mem[4] = HALTW;
    BR_EN = 1; BR_TGT = 5'd4;
    step();
    BR_EN = 0;
    step();
    checks++; if (INSTR !== HALTW || VALID !== 1'b1 || HALTED !== 1'b1 || IMA !== 5'd4) begin
      failures++; $display("FAIL halt_deliver instr=%h v=%b h=%b ima=%0d exp=ffffffff/1/1/4", INSTR, VALID, HALTED, IMA); end
    c = exp_cnt();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (VALID !== 1'b0 || HALTED !== 1'b1 || IMA !== 5'd4 || INSTR !== HALTW || FETCH_CNT !== c) begin
        failures++; $display("FAIL halt_idle%0d v=%b h=%b ima=%0d cnt=%0d exp=0/1/4/%0d", i, VALID, HALTED, IMA, FETCH_CNT, c); end
    end
    BR_EN = 1; BR_TGT = 5'd0;
    step();
    BR_EN = 0;
    checks++; if (HALTED !== 1'b0 || VALID !== 1'b0 || IMA !== 5'd0) begin failures++; $display("FAIL halt_resume h=%b v=%b ima=%0d exp=0/0/0", HALTED, VALID, IMA); end
    step();
    checks++; if (INSTR !== mem[0] || VALID !== 1'b1 || PC_OUT !== 5'd0) begin failures++; $display("FAIL resume_fetch instr=%h v=%b exp=%h/1", INSTR, VALID, mem[0]); end
  endtask

  task automatic test_reset_mid_halt();
    BR_EN = 1; BR_TGT = 5'd4;
    step();
    BR_EN = 0;
    step();
    STALL = 1;
    step();
    checks++; if (HALTED !== 1'b1 || VALID !== 1'b1) begin failures++; $display("FAIL stalled_halt h=%b v=%b exp=1/1", HALTED, VALID); end
    #3 rst_n = 0;
    #1;
    checks++; if (HALTED !== 1'b0 || VALID !== 1'b0 || FETCH_CNT !== 32'd0) begin failures++; $display("FAIL async_rst_flags h=%b v=%b cnt=%0d exp=0/0/0", HALTED, VALID, FETCH_CNT); end
    checks++; if (IMA !== 5'd0 || INSTR !== NOPW) begin failures++; $display("FAIL async_rst_data ima=%0d instr=%h exp=0/0", IMA, INSTR); end
    STALL = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    fill_mem();
    for (int k = 0; k < 3; k++) mem[$urandom_range(31)] = HALTW;
    for (int i = 0; i < 400; i++) begin
      STALL  = ($urandom_range(3) == 0);
      BR_EN  = ($urandom_range(7) == 0);
      BR_TGT = AWL'($urandom_range(31));
      step();
      checks++;
      if (IMA !== AWL'(m_pc) || INSTR !== m_instr || PC_OUT !== AWL'(m_pcout) ||
          VALID !== m_valid || HALTED !== (m_mode == 2) || FETCH_CNT !== exp_cnt()) begin
        failures++;
        $display("FAIL rand%0d ima=%0d/%0d instr=%h/%h pcout=%0d/%0d v=%b/%b h=%b/%b cnt=%0d/%0d (got/exp)",
          i, IMA, m_pc, INSTR, m_instr, PC_OUT, m_pcout, VALID, m_valid, HALTED, (m_mode == 2), FETCH_CNT, exp_cnt());
      end
    end
    STALL = 0; BR_EN = 0;
  endtask

  initial begin
    fill_mem();
    model_reset();
    test_reset();
    test_run();
    test_stall();
    test_branch_over_stall();
    test_wrap();
    test_halt();
    test_reset_mid_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
